// File: rtl/fieldious_pkg.sv
// Shared definitions for the fieldious query path: default geometry of a
// query load and the query-patch loader state encoding.
package fieldious_pkg;

    localparam int DEF_DATA_WIDTH = 11;
    localparam int DEF_PATCH_SIZE = 5;
    localparam int DEF_ROW_SIZE   = 26;
    localparam int DEF_COL_SIZE   = 19;
    localparam int DEF_NUM_QUERYS = DEF_ROW_SIZE * DEF_COL_SIZE;

    // Loader FSM states, also exported on the debug port of the loader.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    // Counter width that stays at least one bit wide for degenerate sizes.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/query_patch_loader_patch_assembler.sv
// Collects PATCH_SIZE stream words into one patch register. Element 0 lands
// in the LSBs; last_word flags that the next accepted word completes a patch.
module patch_assembler
    import fieldious_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PATCH_SIZE = DEF_PATCH_SIZE
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic                             clear,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic                             last_word,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] patch
);

    localparam int              CNTW     = safe_clog2(PATCH_SIZE);
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(PATCH_SIZE - 1);

    logic [CNTW-1:0]                  word_cnt;
    logic [PATCH_SIZE*DATA_WIDTH-1:0] patch_reg;

    assign last_word = (word_cnt == LAST_IDX);
    assign patch     = patch_reg;

    // Element write at the current slot; the slot index wraps after the last element.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            word_cnt  <= '0;
            patch_reg <= '0;
        end else if (clear) begin
            word_cnt <= '0;
        end else if (wr_en) begin
            patch_reg[word_cnt*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
            word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/query_patch_loader.sv
// Query-patch loader: after a start pulse, turns the pixel word stream into
// NUM_QUERYS patches written to query memory addresses 0..NUM_QUERYS-1, then
// pulses load_done. The memory port is decoded from registered state only.
//
// Stream handshake: a word transfers on a rising clock edge where both
// in_valid and in_ready are high. in_ready depends on state only, never on
// in_valid. While in_valid is high and in_ready low the source must hold
// in_data stable; in_data is ignored whenever in_valid is low.
module query_patch_loader
    import fieldious_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PATCH_SIZE = DEF_PATCH_SIZE,
    parameter int ROW_SIZE   = DEF_ROW_SIZE,
    parameter int COL_SIZE   = DEF_COL_SIZE,
    parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    parameter int ADDRW      = safe_clog2(NUM_QUERYS)
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             qp_mem_csb0,
    output logic                             qp_mem_web0,
    output logic [ADDRW-1:0]                 qp_mem_addr0,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] qp_mem_wpatch0,
    output logic                             busy,
    output logic                             load_done,
    output loader_state_e                    state_dbg
);

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(NUM_QUERYS - 1);

    loader_state_e                    state_q, state_d;
    logic [ADDRW-1:0]                 patch_cnt_q, patch_cnt_d;
    logic                             accept;
    logic                             asm_clear;
    logic                             last_word;
    logic [PATCH_SIZE*DATA_WIDTH-1:0] patch_reg;

    assign in_ready  = (state_q == ST_FILL);
    assign accept    = in_valid & in_ready;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

    patch_assembler #(
        .DATA_WIDTH (DATA_WIDTH),
        .PATCH_SIZE (PATCH_SIZE)
    ) u_patch_assembler (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .clear     (asm_clear),
        .wr_en     (accept),
        .wr_data   (in_data),
        .last_word (last_word),
        .patch     (patch_reg)
    );

    // State and patch address registers; reset aborts any load in progress.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            patch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            patch_cnt_q <= patch_cnt_d;
        end
    end

    // Next-state logic plus the memory-port and completion decode.
    always_comb begin
        state_d        = state_q;
        patch_cnt_d    = patch_cnt_q;
        asm_clear      = 1'b0;
        load_done      = 1'b0;
        qp_mem_csb0    = 1'b1;
        qp_mem_web0    = 1'b1;
        qp_mem_addr0   = '0;
        qp_mem_wpatch0 = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FILL;
                    patch_cnt_d = '0;
                    asm_clear   = 1'b1;
                end
            end
            ST_FILL: begin
                if (in_valid && last_word) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                qp_mem_csb0    = 1'b0;
                qp_mem_web0    = 1'b0;
                qp_mem_addr0   = patch_cnt_q;
                qp_mem_wpatch0 = patch_reg;
                if (patch_cnt_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    patch_cnt_d = patch_cnt_q + 1'b1;
                    state_d     = ST_FILL;
                end
            end
            ST_DONE: begin
                load_done   = 1'b1;
                patch_cnt_d = '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_query_patch_loader.sv
// Bench for query_patch_loader: a cycle table on a one-patch instance and
// randomized full loads on a default instance checked against a patch model.
module tb_query_patch_loader;
  import fieldious_pkg::*;

  localparam int DW   = 11;
  localparam int PS   = 5;
  localparam int NQ   = 26 * 19;
  localparam int AW   = 9;
  localparam int PW   = PS * DW;
  localparam int W    = AW + PW;
  localparam int OUTW = 6 + PW;

  // ---------------- clock / reset ----------------
  logic wb_clk_i;
  logic wb_rst_i;
  int   cyc = 0;

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // ---------------- default instance ----------------
  logic          start, in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          csb0, web0, busy, load_done;
  logic [AW-1:0] addr;
  logic [PW-1:0] wpatch;
  loader_state_e state_dbg;

  query_patch_loader dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .qp_mem_csb0    (csb0),
    .qp_mem_web0    (web0),
    .qp_mem_addr0   (addr),
    .qp_mem_wpatch0 (wpatch),
    .busy           (busy),
    .load_done      (load_done),
    .state_dbg      (state_dbg)
  );

  // ---------------- single-patch instance ----------------
  logic          s_start, s_in_valid, s_in_ready;
  logic [DW-1:0] s_in_data;
  logic          s_csb0, s_web0, s_busy, s_load_done;
  logic [0:0]    s_addr;
  logic [PW-1:0] s_wpatch;
  loader_state_e s_state_dbg;

  query_patch_loader #(.ROW_SIZE(1), .COL_SIZE(1)) dut_small (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .start          (s_start),
    .in_valid       (s_in_valid),
    .in_ready       (s_in_ready),
    .in_data        (s_in_data),
    .qp_mem_csb0    (s_csb0),
    .qp_mem_web0    (s_web0),
    .qp_mem_addr0   (s_addr),
    .qp_mem_wpatch0 (s_wpatch),
    .busy           (s_busy),
    .load_done      (s_load_done),
    .state_dbg      (s_state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_item;
  int checks   = 0;
  int errors   = 0;
  int n_writes = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor for the default instance: every write must match the model.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (!csb0) begin
        n_writes++;
        check("write_ctl", 64'({web0, in_ready, busy}), 64'(3'b001));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_unexpected: addr %0d written, no patch pending", addr);
        end else begin
          exp_item = exp_q.pop_front();
          check("write_data", {addr, wpatch}, exp_item);
        end
      end else begin
        check("mem_idle", 64'({web0, addr == '0, wpatch == '0}), 64'(3'b111));
      end
      if (load_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_start();
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  // Present one word and hold it until the loader takes it.
  task automatic send_word(input logic [DW-1:0] d);
    int   waits;
    logic ok;
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge wb_clk_i);
      ok = in_ready;
      tick();
      if (ok) break;
      waits++;
      if (waits > 16) begin
        checks++;
        errors++;
        $display("FAIL send_word: word not taken within 16 cycles");
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  // Stream n_patches random patches (plus extra_words of a partial one).
  // Expected memory contents: patch p holds words 5p..5p+4, first word lowest.
  task automatic feed(input int n_patches, input int extra_words, input bit rand_gaps, input int gap_at);
    logic [DW-1:0] w[PS];
    logic [PW-1:0] p;
    int k, nw;
    k = 0;
    for (int pi = 0; pi <= n_patches; pi++) begin
      nw = (pi < n_patches) ? PS : extra_words;
      if (nw == 0) break;
      for (int j = 0; j < nw; j++) w[j] = DW'($urandom);
      p = '0;
      for (int j = PS - 1; j >= 0; j--) p = (p << DW) | PW'(w[j]);
      if (pi < n_patches) exp_q.push_back({AW'(pi), p});
      for (int j = 0; j < nw; j++) begin
        if (k == gap_at) begin
          in_valid = 1'b0;
          repeat (3) tick();
        end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) tick();
        end
        send_word(w[j]);
        k++;
      end
    end
  endtask

  task automatic wait_done(input int prev, input string name);
    int n;
    n = 0;
    while (done_cnt == prev && n < 40) begin
      @(negedge wb_clk_i);
      #1;
      n++;
    end
    if (done_cnt == prev) begin
      checks++;
      errors++;
      $display("FAIL %s: load_done not seen within 40 cycles", name);
    end
  endtask

  // ---------------- cycle table for the single-patch instance ----------------
  typedef struct {
    logic          st;
    logic          v;
    logic [DW-1:0] d;
    logic [OUTW-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic v, input logic [DW-1:0] d,
                              input logic rdy, input logic bsy, input logic dn,
                              input logic cs, input logic we, input logic a,
                              input logic [PW-1:0] wp);
    vec_t r;
    r.st  = st;
    r.v   = v;
    r.d   = d;
    r.exp = {rdy, bsy, dn, cs, we, a, wp};
    return r;
  endfunction

  logic [PW-1:0] p1, p2;
  logic [OUTW-1:0] s_got;

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int prev_done, w0;

  initial begin
    wb_rst_i   = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    s_start    = 1'b0;
    s_in_valid = 1'b0;
    s_in_data  = '0;

    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("reset_ctl", 64'({in_ready, busy, load_done, csb0, web0}), 64'(5'b00011));
    check("reset_mem", {addr, wpatch}, 64'd0);
    check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    check("reset_small", 64'({s_in_ready, s_busy, s_load_done, s_csb0, s_web0, s_addr, s_wpatch == '0}), 64'(7'b0001101));
    wb_rst_i = 1'b0;
    tick();

    // Single patch, idle stream, restart, start during Done.
    p1 = {11'd5, 11'd4, 11'd3, 11'd2, 11'd1};
    p2 = {11'd14, 11'd13, 11'd12, 11'd11, 11'd10};
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 1,  1, 1, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 2,  1, 1, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 3,  1, 1, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 4,  1, 1, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 5,  1, 1, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 0, 0,  0, 1, 0, 0, 0, 0, p1));
    vecs.push_back(mk(0, 0, 0,  0, 1, 1, 1, 1, 0, '0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 7,  0, 0, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 7,  0, 0, 0, 1, 1, 0, '0));
    vecs.push_back(mk(1, 1, 9,  0, 0, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 10, 1, 1, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 11, 1, 1, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 12, 1, 1, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 13, 1, 1, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 14, 1, 1, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 99, 0, 1, 0, 0, 0, 0, p2));
    vecs.push_back(mk(1, 0, 0,  0, 1, 1, 1, 1, 0, '0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 3,  0, 0, 0, 1, 1, 0, '0));

    for (int i = 0; i < vecs.size(); i++) begin
      s_start    = vecs[i].st;
      s_in_valid = vecs[i].v;
      s_in_data  = vecs[i].d;
      @(negedge wb_clk_i);
      s_got = {s_in_ready, s_busy, s_load_done, s_csb0, s_web0, s_addr, s_wpatch};
      check($sformatf("table_row_%0d", i), 64'(s_got), 64'(vecs[i].exp));
      tick();
    end
    s_start    = 1'b0;
    s_in_valid = 1'b0;

    // Idle stream on the default instance.
    in_valid = 1'b1;
    in_data  = 11'h2aa;
    repeat (4) begin
      @(negedge wb_clk_i);
      check("idle_stream", 64'({in_ready, csb0, busy}), 64'(3'b010));
      tick();
    end
    in_valid = 1'b0;

    // Full load, continuous stream, extra start during patch 3.
    prev_done = done_cnt;
    w0        = n_writes;
    do_start();
    fork
      feed(NQ, 0, 1'b0, -1);
      begin
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    join
    wait_done(prev_done, "full_done");
    check("full_latency", 64'(done_cyc - start_cyc), 64'd2965);
    @(negedge wb_clk_i);
    check("full_busy_after", 64'({busy, in_ready}), 64'd0);
    repeat (3) tick();
    check("full_done_count", 64'(done_cnt - prev_done), 64'd1);
    check("full_writes", 64'(n_writes - w0), 64'(NQ));
    check("full_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset during Fill of patch 10.
    prev_done = done_cnt;
    w0        = n_writes;
    do_start();
    feed(10, 2, 1'b0, -1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("rst_async_ctl", 64'({in_ready, busy, load_done, csb0, web0}), 64'(5'b00011));
    check("rst_async_mem", {addr, wpatch}, 64'd0);
    check("rst_writes", 64'(n_writes - w0), 64'd10);
    check("rst_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) tick();
    wb_rst_i = 1'b0;
    repeat (6) tick();
    check("rst_no_done", 64'(done_cnt - prev_done), 64'd0);

    // Backpressure: random gaps plus a 3-cycle drop inside patch 7.
    prev_done = done_cnt;
    w0        = n_writes;
    do_start();
    feed(NQ, 0, 1'b1, 7 * PS + 2);
    wait_done(prev_done, "bp_done");
    repeat (3) tick();
    check("bp_done_count", 64'(done_cnt - prev_done), 64'd1);
    check("bp_writes", 64'(n_writes - w0), 64'(NQ));
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("bp_idle_after", 64'({busy, state_dbg == ST_IDLE}), 64'(2'b01));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/query_patch_loader.md
Name: query_patch_loader

Overview:
- Upstream feeder of the query-patch memory write port (the qp_mem csb0/web0/addr0/wpatch0 port that the Wishbone controller also drives in debug mode).
- On a start pulse (wbs_fsm_start), accepts a stream of DATA_WIDTH-bit pixel words from the IO pads.
- Assembles every PATCH_SIZE words into one patch and writes the patches to consecutive query-memory addresses 0..NUM_QUERYS-1.
- Pulses load_done (wired to acc_load_done) when the last patch is written.

Parameters:
- DATA_WIDTH, 11, bits per patch element.
- PATCH_SIZE, 5, elements per patch.
- ROW_SIZE, 26, query rows.
- COL_SIZE, 19, query columns.
- NUM_QUERYS, ROW_SIZE*COL_SIZE, patches per load.
- ADDRW, $clog2(NUM_QUERYS), query memory address width.

Ports:
- wb_clk_i  input  1  clock
- wb_rst_i  input  1  asynchronous active-high reset
- start  input  1  single-cycle load request
- in_valid  input  1  stream word valid
- in_ready  output  1  loader accepts word this cycle
- in_data  input  DATA_WIDTH  stream word
- qp_mem_csb0  output  1  query memory chip select, active-low
- qp_mem_web0  output  1  query memory write enable, active-low
- qp_mem_addr0  output  ADDRW  query memory address
- qp_mem_wpatch0  output  PATCH_SIZE*DATA_WIDTH  write patch
- busy  output  1  high from the cycle after start until the cycle after load_done
- load_done  output  1  single-cycle completion pulse

Behaviour:
- Reset and clock: wb_rst_i is asynchronous, active-high; clock is wb_clk_i.
- Reset values:
  - state Idle; word_cnt 0; patch_cnt 0; patch_reg 0.
  - in_ready 0; busy 0; load_done 0.
  - qp_mem_csb0 1; qp_mem_web0 1; addr 0; wpatch 0.
- Memory outputs are decoded combinationally from registered state, counters and patch_reg. They stay at their inactive values (csb0=1, web0=1, addr=0, wpatch=0) in every state except Write.
- FSM states are Idle, Fill, Write, Done.
- Idle:
  - in_ready=0.
  - start=1: next state Fill; word_cnt and patch_cnt cleared.
- Fill:
  - in_ready=1.
  - A word is accepted when in_valid & in_ready. It is stored at patch_reg[word_cnt*DATA_WIDTH +: DATA_WIDTH], so element 0 sits in the LSBs.
  - word_cnt increments per accepted word.
  - On accepting word PATCH_SIZE-1: word_cnt goes to 0 and next state is Write.
  - in_valid=0: hold state, no change.
- Write (exactly 1 cycle):
  - in_ready=0; csb0=0; web0=0; addr0=patch_cnt; wpatch0=patch_reg.
  - patch_cnt==NUM_QUERYS-1: next state Done.
  - Otherwise: patch_cnt+1, next state Fill.
- Done (1 cycle):
  - load_done=1; next state Idle.
  - patch_cnt is cleared on the exit.
- Throughput: PATCH_SIZE+1 cycles per patch with in_valid held high. First write occurs PATCH_SIZE+1 cycles after start is sampled.
- load_done is asserted 1 cycle after the final Write cycle.
- busy = (state != Idle).
- Boundary conditions:
  - start while not Idle is ignored; counters are unaffected.
  - start in the same cycle as load_done is ignored (state is Done, not Idle).
  - in_valid in Idle or Write is not accepted (in_ready=0). The data is not consumed, and the source must hold it.
  - patch_cnt never exceeds NUM_QUERYS-1; no wrap-around write past the last address.
  - Reset asserted mid-load aborts immediately. No further writes occur, load_done is not pulsed, and the partial patch is discarded.
  - in_data is don't-care when in_valid=0.

Decomposition:
- Shared package fieldious_pkg holds:
  - default DATA_WIDTH, PATCH_SIZE, ROW_SIZE, COL_SIZE, NUM_QUERYS;
  - loader state enum (Idle, Fill, Write, Done).
- One natural sub-module: patch_assembler.
  - Owns word_cnt and patch_reg: indexed element write, last-word flag, clear.
  - The top level keeps the FSM, patch_cnt and the memory-port decode.

Test Plan:
- Single patch: NUM_QUERYS=1; start; stream words 1,2,3,4,5 back-to-back.
  - Expect one Write cycle with csb0=0, web0=0, addr0=0, wpatch0={11'd5,11'd4,11'd3,11'd2,11'd1}.
  - load_done 1 cycle later; busy low the following cycle.
- Backpressure: default params; drop in_valid for 3 cycles between words 2 and 3 of patch 7.
  - Expect no extra Write.
  - addr0=7 with correct data.
  - Total Write cycles exactly 494, addresses 0..493 in order.
- Full-run timing: default params with continuous in_valid.
  - Expect load_done exactly 494*6+1 cycles after the Write cycle's reference start point, i.e. 2965 cycles after start is sampled.
  - in_ready low in every Write cycle.
- Start while busy: pulse start again during patch 3.
  - Expect patch_cnt unaffected, no restart, single load_done at the normal time.
- Reset mid-load: assert wb_rst_i during Fill of patch 10.
  - Expect all outputs at reset values asynchronously; no load_done.
  - A subsequent start writes again from addr0=0.
- Idle stream: in_valid=1 with no start.
  - Expect in_ready=0, csb0=1, no writes, busy=0.
